set_bit_serializer: RTL and testbench

//   Input-side stage that sits ahead of the day21 second-set-bit finder.

---
 rtl/set_bit_serializer.sv | 89 ++++++++
 tb/tb_set_bit_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/set_bit_serializer.sv
// Serializes a request vector into one beat per set bit, LSB first.
// Each beat carries the one-hot, binary index and ordinal of the bit it reports.
module set_bit_serializer #(
    parameter int WIDTH = 12,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int ORD_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_vec_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_onehot_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic [ORD_W-1:0] out_ord_o,
    output logic             out_last_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pend;
    logic [ORD_W-1:0] ord;

    logic [WIDTH-1:0] lowest;
    logic [IDX_W-1:0] lowest_idx;
    logic             lowest_last;
    logic             serving;

    // Reset gates the handshake flags so nothing is offered or taken while it is held.
    assign serving     = (state == SERVE) && !reset;
    assign in_ready_o  = (state == IDLE) && !reset;
    assign out_valid_o = serving;

    assign lowest      = pend & (~pend + WIDTH'(1));
    assign lowest_last = (pend & ~lowest) == '0;

    always_comb begin
        lowest_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (lowest[i]) begin
                lowest_idx = lowest_idx | IDX_W'(i);
            end
        end
    end

    assign out_onehot_o = serving ? lowest      : '0;
    assign out_idx_o    = serving ? lowest_idx  : '0;
    assign out_ord_o    = serving ? ord         : '0;
    assign out_last_o   = serving ? lowest_last : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pend  <= '0;
            ord   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i && in_vec_i != '0) begin
                        pend  <= in_vec_i;
                        ord   <= '0;
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (out_ready_i) begin
                        pend <= pend & ~lowest;
                        if (lowest_last) begin
                            ord   <= '0;
                            state <= IDLE;
                        end else begin
                            ord <= ord + ORD_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Bench for set_bit_serializer: directed cases plus random traffic, every cycle
// compared against a queue-of-set-bit-positions reference model.
module tb_set_bit_serializer;

    localparam int WIDTH = 12;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int ORD_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_vec_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_onehot_o;
    logic [IDX_W-1:0] out_idx_o;
    logic [ORD_W-1:0] out_ord_o;
    logic             out_last_o;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining set-bit positions of the vector in service.
    int model_q[$];
    int model_ord = 0;
    int beats     = 0;

    always #5 clk = ~clk;

    set_bit_serializer #(.WIDTH(WIDTH), .IDX_W(IDX_W), .ORD_W(ORD_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_vec_i     (in_vec_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_onehot_o (out_onehot_o),
        .out_idx_o    (out_idx_o),
        .out_ord_o    (out_ord_o),
        .out_last_o   (out_last_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        busy;
        logic [31:0] e_onehot;
        busy     = !reset && (model_q.size() > 0);
        e_onehot = busy ? (32'd1 << model_q[0]) : 32'd0;
        check("in_ready", {31'd0, in_ready_o}, {31'd0, !reset && !busy});
        check("out_valid", {31'd0, out_valid_o}, {31'd0, busy});
        check("out_onehot", 32'(out_onehot_o), e_onehot);
        check("out_idx", 32'(out_idx_o), busy ? 32'(model_q[0]) : 32'd0);
        check("out_ord", 32'(out_ord_o), busy ? 32'(model_ord) : 32'd0);
        check("out_last", {31'd0, out_last_o}, {31'd0, busy && model_q.size() == 1});
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            model_ord = 0;
        end else if (model_q.size() == 0) begin
            if (in_valid_i) begin
                for (int b = 0; b < WIDTH; b++) begin
                    if ((in_vec_i >> b) & 1) model_q.push_back(b);
                end
                model_ord = 0;
            end
        end else if (out_ready_i) begin
            void'(model_q.pop_front());
            beats++;
            model_ord = (model_q.size() == 0) ? 0 : model_ord + 1;
        end
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic send(input logic [WIDTH-1:0] v);
        in_valid_i = 1'b1;
        in_vec_i   = v;
        cycle();
        in_valid_i = 1'b0;
        in_vec_i   = '0;
    endtask

    initial begin
        int b0;
        reset       = 1'b1;
        in_valid_i  = 1'b0;
        in_vec_i    = '0;
        out_ready_i = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycle();

        // 12'h025 with a ready sink: beats idx 0,2,5 then idle
        out_ready_i = 1'b1;
        b0 = beats;
        send(12'h025);
        cycles(4);
        check("beats_025", 32'(beats - b0), 32'd3);

        // 12'h800 under backpressure for 3 cycles, then released
        out_ready_i = 1'b0;
        b0 = beats;
        send(12'h800);
        cycles(3);
        check("stall_no_beat", 32'(beats - b0), 32'd0);
        out_ready_i = 1'b1;
        cycles(2);
        check("beats_800", 32'(beats - b0), 32'd1);

        // zero vector is consumed with no beat
        b0 = beats;
        send(12'h000);
        cycles(2);
        check("beats_000", 32'(beats - b0), 32'd0);

        // all ones: 12 beats
        b0 = beats;
        send(12'hFFF);
        cycles(13);
        check("beats_fff", 32'(beats - b0), 32'd12);

        // reset after two beats discards the rest
        b0 = beats;
        send(12'hFFF);
        cycles(2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycles(2);
        check("beats_reset", 32'(beats - b0), 32'd2);
        b0 = beats;
        send(12'h002);
        cycles(2);
        check("beats_002", 32'(beats - b0), 32'd1);

        // new vector offered while serving is held off until idle
        b0 = beats;
        in_valid_i = 1'b1;
        in_vec_i   = 12'h030;
        cycle();
        in_vec_i = 12'h001;
        cycles(3);
        in_valid_i = 1'b0;
        in_vec_i   = '0;
        cycles(2);
        check("beats_030_001", 32'(beats - b0), 32'd3);

        // random traffic
        for (int k = 0; k < 1000; k++) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            in_vec_i    = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            out_ready_i = 1'($urandom_range(0, 3) != 0);
            reset       = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
